// File: rtl/regfile_scoreboard_pkg.sv
// Shared pipeline constants for the register file / writeback scoreboard slice.
// Data width, register address width and the writeback byte-enable encoding live here.
package regfile_scoreboard_pkg;

    localparam int RF_DATA_W = 16;
    localparam int RF_ADDR_W = 3;
    localparam int BP_W      = 2;

    // bp bit n enables byte n of the writeback word
    localparam logic [BP_W-1:0] BP_NONE = 2'b00;
    localparam logic [BP_W-1:0] BP_LO   = 2'b01;
    localparam logic [BP_W-1:0] BP_HI   = 2'b10;
    localparam logic [BP_W-1:0] BP_BOTH = 2'b11;

    typedef struct packed {
        logic                 we;
        logic [RF_ADDR_W-1:0] dest;
        logic [BP_W-1:0]      bp;
    } wb_ctl_t;

    typedef struct packed {
        logic                 valid;
        logic [RF_ADDR_W-1:0] dest;
    } issue_req_t;

endpackage

// File: rtl/regfile_scoreboard_counter.sv
// sb_counter: one pending-write counter; counts issues up and retires down, never wraps.
module sb_counter
    import regfile_scoreboard_pkg::*;
#(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] cnt,
    output logic             at_max,
    output logic             is_zero
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    always_ff @(posedge clk) begin
        if (reset)
            cnt <= '0;
        else if (inc && !dec && cnt != CNT_MAX)
            cnt <= cnt + 1'b1;
        else if (dec && !inc && cnt != '0)
            cnt <= cnt - 1'b1;
    end

    assign at_max  = (cnt == CNT_MAX);
    assign is_zero = (cnt == '0);

endmodule

// File: rtl/regfile_scoreboard.sv
// Flip-flop register file with byte-enabled writeback, write-through read bypass,
// and a per-register pending-write scoreboard gating instruction issue.
module regfile_scoreboard
    import regfile_scoreboard_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W,
    parameter int NREG   = 8,
    parameter int CNT_W  = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATA_W-1:0]    wb_result,
    input  logic [RF_ADDR_W-1:0] destReg_addr,
    input  logic                 we,
    input  logic [BP_W-1:0]      bp,
    input  logic                 issue_valid,
    input  logic [RF_ADDR_W-1:0] issue_dest,
    output logic                 issue_ready,
    input  logic [RF_ADDR_W-1:0] rd_addr_a,
    input  logic [RF_ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0]    rd_data_a,
    output logic [DATA_W-1:0]    rd_data_b,
    output logic                 rd_busy_a,
    output logic                 rd_busy_b,
    output logic                 wb_orphan
);

    wb_ctl_t    wb;
    issue_req_t iss;

    logic [NREG-1:0][DATA_W-1:0] regs;
    logic [NREG-1:0][CNT_W-1:0]  cnt;
    logic [NREG-1:0]             at_max, is_zero, inc, dec;
    logic [DATA_W-1:0]           wmask;
    logic                        retire, accept;

    assign wb  = '{we: we, dest: destReg_addr, bp: bp};
    assign iss = '{valid: issue_valid, dest: issue_dest};

    // Bytes beyond the two covered by bp are never written by writeback.
    for (genvar j = 0; j < DATA_W; j++) begin : g_mask
        if (j / 8 < BP_W) begin : g_en
            assign wmask[j] = wb.bp[j/8];
        end else begin : g_off
            assign wmask[j] = 1'b0;
        end
    end

    assign retire      = wb.we && !is_zero[wb.dest];
    // A retire to the same register frees the slot this issue would need.
    assign issue_ready = !(at_max[iss.dest] && !(retire && wb.dest == iss.dest));
    assign accept      = iss.valid && issue_ready;

    for (genvar i = 0; i < NREG; i++) begin : g_reg
        assign inc[i] = accept && iss.dest == RF_ADDR_W'(i);
        assign dec[i] = retire && wb.dest == RF_ADDR_W'(i);

        always_ff @(posedge clk) begin
            if (reset)
                regs[i] <= '0;
            else if (wb.we && wb.dest == RF_ADDR_W'(i))
                regs[i] <= (regs[i] & ~wmask) | (wb_result & wmask);
        end
    end

    sb_counter #(.CNT_W(CNT_W)) u_cnt [NREG-1:0] (
        .clk     (clk),
        .reset   (reset),
        .inc     (inc),
        .dec     (dec),
        .cnt     (cnt),
        .at_max  (at_max),
        .is_zero (is_zero)
    );

    always_ff @(posedge clk) begin
        if (reset)
            wb_orphan <= 1'b0;
        else if (wb.we && is_zero[wb.dest])
            wb_orphan <= 1'b1;
    end

    always_comb begin
        rd_data_a = regs[rd_addr_a];
        if (wb.we && rd_addr_a == wb.dest)
            rd_data_a = (regs[rd_addr_a] & ~wmask) | (wb_result & wmask);
    end

    always_comb begin
        rd_data_b = regs[rd_addr_b];
        if (wb.we && rd_addr_b == wb.dest)
            rd_data_b = (regs[rd_addr_b] & ~wmask) | (wb_result & wmask);
    end

    // Last outstanding write retiring this cycle: bypassed data is final.
    assign rd_busy_a = !is_zero[rd_addr_a] &&
                       !(cnt[rd_addr_a] == CNT_W'(1) && retire && wb.dest == rd_addr_a);
    assign rd_busy_b = !is_zero[rd_addr_b] &&
                       !(cnt[rd_addr_b] == CNT_W'(1) && retire && wb.dest == rd_addr_b);

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: directed scenarios then random traffic, all
// outputs compared each cycle against an array/counter reference model.
module tb_regfile_scoreboard;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] wb_result;
    logic [2:0]  destReg_addr;
    logic        we;
    logic [1:0]  bp;
    logic        issue_valid;
    logic [2:0]  issue_dest;
    logic        issue_ready;
    logic [2:0]  rd_addr_a, rd_addr_b;
    logic [15:0] rd_data_a, rd_data_b;
    logic        rd_busy_a, rd_busy_b;
    logic        wb_orphan;

    int n_vec = 0;
    int n_err = 0;

    logic [15:0] m_reg [8];
    int          m_cnt [8];
    bit          m_orphan;

    always #5 clk = ~clk;

    regfile_scoreboard dut (
        .clk          (clk),
        .reset        (reset),
        .wb_result    (wb_result),
        .destReg_addr (destReg_addr),
        .we           (we),
        .bp           (bp),
        .issue_valid  (issue_valid),
        .issue_dest   (issue_dest),
        .issue_ready  (issue_ready),
        .rd_addr_a    (rd_addr_a),
        .rd_addr_b    (rd_addr_b),
        .rd_data_a    (rd_data_a),
        .rd_data_b    (rd_data_b),
        .rd_busy_a    (rd_busy_a),
        .rd_busy_b    (rd_busy_b),
        .wb_orphan    (wb_orphan)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] exp_rd(input logic [2:0] a);
        logic [15:0] v;
        v = m_reg[a];
        if (we && a == destReg_addr) begin
            if (bp[0]) v[7:0]  = wb_result[7:0];
            if (bp[1]) v[15:8] = wb_result[15:8];
        end
        return v;
    endfunction

    function automatic bit exp_busy(input logic [2:0] a);
        return m_cnt[a] != 0 && !(we && destReg_addr == a && m_cnt[a] == 1);
    endfunction

    function automatic bit exp_ready();
        return !(m_cnt[issue_dest] == 3 && !(we && destReg_addr == issue_dest));
    endfunction

    task automatic drive(input bit r, input bit w, input logic [2:0] d, input logic [1:0] b,
                         input logic [15:0] v, input bit iv, input logic [2:0] id,
                         input logic [2:0] ra, input logic [2:0] rb);
        reset = r; we = w; destReg_addr = d; bp = b; wb_result = v;
        issue_valid = iv; issue_dest = id; rd_addr_a = ra; rd_addr_b = rb;
    endtask

    // Check all outputs against the model, clock once, then advance the model.
    task automatic tick();
        bit acc, ret;
        #1;
        chk("rd_data_a", 32'(rd_data_a), 32'(exp_rd(rd_addr_a)));
        chk("rd_data_b", 32'(rd_data_b), 32'(exp_rd(rd_addr_b)));
        chk("rd_busy_a", 32'(rd_busy_a), 32'(exp_busy(rd_addr_a)));
        chk("rd_busy_b", 32'(rd_busy_b), 32'(exp_busy(rd_addr_b)));
        chk("issue_ready", 32'(issue_ready), 32'(exp_ready()));
        chk("wb_orphan", 32'(wb_orphan), 32'(m_orphan));
        acc = issue_valid && exp_ready();
        @(posedge clk);
        if (reset) begin
            for (int i = 0; i < 8; i++) begin m_reg[i] = '0; m_cnt[i] = 0; end
            m_orphan = 0;
        end else begin
            ret = 0;
            if (we) begin
                m_reg[destReg_addr] = exp_rd(destReg_addr);
                ret = m_cnt[destReg_addr] != 0;
                if (!ret) m_orphan = 1;
            end
            if (acc) m_cnt[issue_dest]++;
            if (ret) m_cnt[destReg_addr]--;
        end
        @(negedge clk);
    endtask

    task automatic idle(input logic [2:0] ra, input logic [2:0] rb);
        drive(0, 0, 0, 2'b00, 16'h0, 0, 0, ra, rb);
    endtask

    initial begin
        for (int i = 0; i < 8; i++) begin m_reg[i] = 16'hxxxx; m_cnt[i] = 0; end
        m_orphan = 0;
        drive(1, 0, 0, 2'b00, 16'h0, 0, 0, 0, 0);
        @(negedge clk);
        @(posedge clk);
        for (int i = 0; i < 8; i++) m_reg[i] = '0;
        @(negedge clk);

        // Reset state
        drive(1, 0, 0, 2'b00, 16'h0, 0, 0, 0, 7);
        #1;
        chk("rst_data", 32'(rd_data_a), 32'h0);
        chk("rst_busy", 32'(rd_busy_b), 32'h0);
        chk("rst_ready", 32'(issue_ready), 32'h1);
        chk("rst_orphan", 32'(wb_orphan), 32'h0);
        tick();

        // R3 = BEEF, visible next cycle and not busy
        drive(0, 1, 3, 2'b11, 16'hBEEF, 0, 0, 0, 0);
        tick();
        idle(3, 0);
        #1;
        chk("r3_data", 32'(rd_data_a), 32'hBEEF);
        chk("r3_busy", 32'(rd_busy_a), 32'h0);
        tick();

        // Byte-enabled write with same-cycle bypass
        drive(0, 1, 5, 2'b11, 16'h1234, 0, 0, 0, 5);
        tick();
        drive(0, 1, 5, 2'b10, 16'hAB00, 0, 0, 0, 5);
        #1;
        chk("r5_bypass", 32'(rd_data_b), 32'hAB34);
        tick();
        idle(0, 5);
        #1;
        chk("r5_stored", 32'(rd_data_b), 32'hAB34);
        tick();

        // bp=00: no data change
        drive(0, 1, 5, 2'b00, 16'hFFFF, 0, 0, 5, 5);
        tick();
        idle(5, 0);
        #1;
        chk("r5_bp00", 32'(rd_data_a), 32'hAB34);
        tick();

        // Fill R2 to max, blocked fourth issue, then retire-unblocks
        repeat (3) begin drive(0, 0, 0, 2'b00, 0, 1, 2, 2, 0); tick(); end
        drive(0, 0, 0, 2'b00, 0, 1, 2, 2, 0);
        #1;
        chk("r2_full_ready", 32'(issue_ready), 32'h0);
        tick();
        drive(0, 1, 2, 2'b11, 16'h2222, 1, 2, 2, 0);
        #1;
        chk("r2_retire_ready", 32'(issue_ready), 32'h1);
        tick();
        drive(0, 0, 0, 2'b00, 0, 1, 2, 2, 0);
        #1;
        chk("r2_still_full", 32'(issue_ready), 32'h0);
        chk("r2_busy", 32'(rd_busy_a), 32'h1);
        tick();
        repeat (3) begin drive(0, 1, 2, 2'b11, 16'h2200, 0, 0, 2, 0); tick(); end
        idle(2, 0);
        #1;
        chk("r2_drained", 32'(rd_busy_a), 32'h0);
        tick();

        // Last retire of R1 clears busy in the same cycle
        drive(0, 0, 0, 2'b00, 0, 1, 1, 1, 0);
        tick();
        drive(0, 1, 1, 2'b11, 16'h5A5A, 0, 0, 1, 0);
        #1;
        chk("r1_busy_retire", 32'(rd_busy_a), 32'h0);
        chk("r1_bypass", 32'(rd_data_a), 32'h5A5A);
        tick();

        // Orphan writeback to R6; sticky until reset
        drive(0, 0, 0, 2'b00, 0, 0, 0, 0, 0); tick();
        drive(1, 0, 0, 2'b00, 0, 0, 0, 0, 0); tick();
        drive(0, 1, 6, 2'b11, 16'h7777, 0, 0, 6, 0);
        tick();
        idle(6, 0);
        #1;
        chk("r6_orphan", 32'(wb_orphan), 32'h1);
        chk("r6_data", 32'(rd_data_a), 32'h7777);
        tick();
        idle(0, 0);
        #1;
        chk("r6_orphan_sticky", 32'(wb_orphan), 32'h1);
        tick();
        drive(1, 0, 0, 2'b00, 0, 0, 0, 0, 0); tick();
        idle(0, 0);
        #1;
        chk("orphan_cleared", 32'(wb_orphan), 32'h0);
        tick();

        // Reset drops pending writes to R4; a later writeback is an orphan
        repeat (2) begin drive(0, 0, 0, 2'b00, 0, 1, 4, 4, 0); tick(); end
        idle(4, 0);
        #1;
        chk("r4_busy_pre", 32'(rd_busy_a), 32'h1);
        tick();
        drive(1, 0, 0, 2'b00, 0, 0, 0, 4, 0); tick();
        idle(4, 0);
        #1;
        chk("r4_busy_post", 32'(rd_busy_a), 32'h0);
        tick();
        drive(0, 1, 4, 2'b01, 16'h0044, 0, 0, 4, 0); tick();
        idle(4, 0);
        #1;
        chk("r4_orphan", 32'(wb_orphan), 32'h1);
        tick();
        drive(1, 0, 0, 2'b00, 0, 0, 0, 0, 0); tick();

        // Random traffic; writebacks mostly target registers with pending writes
        for (int n = 0; n < 600; n++) begin
            logic [2:0] d;
            d = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) != 0)
                for (int k = 0; k < 8; k++)
                    if (m_cnt[3'(d + 3'(k))] != 0) begin d = 3'(d + 3'(k)); break; end
            drive($urandom_range(0, 99) < 2, $urandom_range(0, 9) < 4, d,
                  2'($urandom_range(0, 3)), 16'($urandom), $urandom_range(0, 1) == 1,
                  3'($urandom_range(0, 7)),
                  ($urandom_range(0, 2) == 0) ? d : 3'($urandom_range(0, 7)),
                  3'($urandom_range(0, 7)));
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/regfile_scoreboard.md
REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

Interface
REQ-001 Parameter DATA_W, default 16, register and data width.
REQ-002 Parameter NREG, default 8, number of architectural registers; address width is 3.
REQ-003 Parameter CNT_W, default 2, width of the per-register pending-write counter.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 wb_result  input  DATA_W  writeback data from the writeback stage.
REQ-007 destReg_addr  input  3  writeback destination register.
REQ-008 we  input  1  writeback write enable.
REQ-009 bp  input  2  writeback byte enables: bit1 selects [15:8], bit0 selects [7:0].
REQ-010 issue_valid  input  1  an instruction with a register destination issues this cycle.
REQ-011 issue_dest  input  3  destination register of the issuing instruction.
REQ-012 issue_ready  output  1  the issue can be accepted this cycle.
REQ-013 rd_addr_a, rd_addr_b  input  3 each  read port addresses.
REQ-014 rd_data_a, rd_data_b  output  DATA_W each  read data.
REQ-015 rd_busy_a, rd_busy_b  output  1 each  the addressed register still has an outstanding write.
REQ-016 wb_orphan  output  1  sticky error: a writeback arrived with no pending write.

Function
REQ-017 Storage: NREG x DATA_W registers; all registers, including register 0, are writable.
REQ-018 Write: when we=1, on the clock edge update only the bytes of reg[destReg_addr] whose bp bit is 1; when bp=00, no data changes but the scoreboard still updates.
REQ-019 Read: combinational; if we=1 and rd_addr equals destReg_addr, each byte enabled by bp is taken from wb_result and the other bytes from storage (write-through bypass).
REQ-020 Counters: one CNT_W-bit pending counter per register, with range 0..2^CNT_W-1.
REQ-021 Accepted issue: issue_valid=1 and issue_ready=1; it increments cnt[issue_dest].
REQ-022 Retire: we=1 with cnt[destReg_addr]!=0; it decrements that counter.
REQ-023 Simultaneous accepted issue and retire to the same register leave its counter unchanged; to different registers, both counters update.
REQ-024 issue_ready = 0 only when cnt[issue_dest] is at maximum and no retire targets issue_dest in the same cycle; otherwise issue_ready = 1.
REQ-025 An issue with issue_ready=0 is ignored; the issuer holds issue_valid and issue_dest until the issue is accepted.
REQ-026 rd_busy_x = 1 iff cnt[rd_addr_x] != 0, except it is 0 when cnt[rd_addr_x]==1 and a retire targets rd_addr_x this cycle; the bypassed data is then final.
REQ-027 Orphan writeback: we=1 with cnt[destReg_addr]==0 still writes data per REQ-018, leaves the counter at 0, and sets wb_orphan, which stays 1 until reset.
REQ-028 Counters never wrap; increment at maximum and decrement at zero are impossible by REQ-024 and REQ-027.
REQ-029 Latency: write data and counters are visible through storage one cycle after the edge; through the bypass they are visible in the same cycle.

Reset
REQ-030 reset=1 on an edge clears all registers to 0, all counters to 0, and wb_orphan to 0; that edge's write and issue are discarded.
REQ-031 During reset: rd_data follows REQ-019 combinationally, rd_busy reflects the counters, and issue_ready=1 once the counters are zero.
REQ-032 A reset asserted mid-operation drops all outstanding writes; any later writeback of those writes is an orphan.

Structure
REQ-033 DATA_W, the register address width, and the bp byte-enable encoding belong in the shared pipeline package.
REQ-034 One sub-module is natural: sb_counter (a single saturating up/down pending counter), instantiated NREG times.
REQ-035 Storage is a flip-flop array, not an inferred RAM, because it needs two asynchronous read ports plus bypass.

Verification
REQ-036 Reset, then write R3=0xBEEF with bp=11; the next cycle rd_addr_a=3 -> rd_data_a=0xBEEF and rd_busy_a=0.
REQ-037 R5=0x1234, then we with bp=10 and wb_result=0xAB00, rd_addr_b=5 in the same cycle -> rd_data_b=0xAB34 in that cycle and in the next.
REQ-038 Issue R2 three times (CNT_W=2), fourth issue with no retire -> issue_ready=0 and the counter stays at 3; add a retire to R2 in the same cycle -> issue_ready=1 and the counter stays at 3.
REQ-039 cnt[R1]=1, retire R1 with rd_addr_a=1 -> rd_busy_a=0 in the same cycle and the data is bypassed.
REQ-040 we to R6 with cnt[R6]=0 -> data is written, wb_orphan=1 and stays 1; reset -> wb_orphan=0.
REQ-041 Issue R4 twice, then reset, then writeback to R4 -> cnt[R4]=0 after the reset, and the writeback sets wb_orphan.
